// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between an instruction-fetch
// requester (i_*) and a load/store requester (d_*).
//   clk, rst      : clock, asynchronous active-high reset
//   i_req/i_addr  : fetch request        -> i_gnt, i_rvalid, i_rdata
//   d_req/d_we/d_addr/d_wdata/d_be : data request -> d_gnt, d_rvalid, d_rdata
//   m_*           : memory request (m_req/m_ready handshake), in-order m_rvalid/m_rdata
//   busy          : transactions outstanding; err : sticky response-without-request flag
// Grants and response routing are combinational (zero added latency).
module mem_bus_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        err
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CNT_W = 3;
  localparam logic [3:0]  MAX_W = 4'(MAX_WAIT);

  logic [DEPTH-1:0] r_owner;   // owner FIFO storage: 0 = fetch, 1 = data
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_starve;
  logic             r_err;

  logic w_full;
  logic w_block;
  logic w_sel_fetch;
  logic w_push;
  logic w_pop;
  logic w_head;

  // Full FIFO only blocks when no response frees a slot this same cycle.
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_block     = w_full && !m_rvalid;
  assign w_sel_fetch = i_req && (!d_req || (r_starve == MAX_W));
  assign w_push      = m_req && m_ready;
  assign w_pop       = !rst && m_rvalid && (r_count != '0);
  assign w_head      = r_owner[r_rd_ptr];

  // Request mux, grants and response routing.
  always_comb begin
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_be     = '0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    if (!rst && (i_req || d_req) && !w_block) begin
      m_req = 1'b1;
      if (w_sel_fetch) begin
        m_addr = i_addr;
        m_be   = 4'hF;
        i_gnt  = m_ready;
      end else begin
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_be    = d_be;
        d_gnt   = m_ready;
      end
    end
    if (w_pop) begin
      i_rvalid = !w_head;
      d_rvalid = w_head;
    end
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign busy    = (r_count != '0);
  assign err     = r_err;

  // Owner FIFO, outstanding count, starvation counter and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_owner[r_wr_ptr] <= !w_sel_fetch;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (m_rvalid && (r_count == '0)) begin
        r_err <= 1'b1;
      end
      if (!i_req || (w_push && w_sel_fetch)) begin
        r_starve <= '0;
      end else if (w_push && (r_starve != MAX_W)) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_mem_bus_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, m_ready, m_rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_be;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, busy, err;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;

  mem_bus_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns each outstanding request, starvation count, error flag.
  bit q[$];
  int starve = 0;
  bit m_err  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model across the rising edge.
  task automatic step(input string tag, input logic r,
                      input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dwe, input logic [31:0] da,
                      input logic [31:0] dwd, input logic [3:0] dbe,
                      input logic mrdy, input logic mrv, input logic [31:0] mrd,
                      output logic o_ig, output logic o_dg);
    int  sz;
    bit  blocked, mreq, sf, xfer, pop;
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da;
    d_wdata = dwd; d_be = dbe; m_ready = mrdy; m_rvalid = mrv; m_rdata = mrd;
    #1;
    sz      = q.size();
    blocked = (sz == DEPTH) && !mrv;
    mreq    = !r && (ir || dr) && !blocked;
    sf      = ir && (!dr || starve == MAX_WAIT);
    xfer    = mreq && mrdy;
    pop     = !r && mrv && (sz > 0);
    check_eq({tag, ".m_req"},    m_req,    mreq);
    check_eq({tag, ".i_gnt"},    i_gnt,    xfer && sf);
    check_eq({tag, ".d_gnt"},    d_gnt,    xfer && !sf);
    check_eq({tag, ".m_addr"},   m_addr,   !mreq ? 32'h0 : (sf ? ia : da));
    check_eq({tag, ".m_we"},     m_we,     mreq && !sf && dwe);
    check_eq({tag, ".m_wdata"},  m_wdata,  (mreq && !sf) ? dwd : 32'h0);
    check_eq({tag, ".m_be"},     m_be,     !mreq ? 32'h0 : (sf ? 32'hF : 32'(dbe)));
    check_eq({tag, ".i_rvalid"}, i_rvalid, pop && (q[0] == 1'b0));
    check_eq({tag, ".d_rvalid"}, d_rvalid, pop && (q[0] == 1'b1));
    check_eq({tag, ".i_rdata"},  i_rdata,  mrd);
    check_eq({tag, ".d_rdata"},  d_rdata,  mrd);
    check_eq({tag, ".busy"},     busy,     !r && (sz > 0));
    check_eq({tag, ".err"},      err,      !r && m_err);
    o_ig = i_gnt;
    o_dg = d_gnt;
    @(posedge clk);
    if (r) begin
      q.delete(); starve = 0; m_err = 1'b0;
    end else begin
      if (mrv && sz == 0) m_err = 1'b1;
      if (pop) void'(q.pop_front());
      if (xfer) q.push_back(!sf);
      if (!ir || (xfer && sf)) starve = 0;
      else if (xfer && starve < MAX_WAIT) starve++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic mrv);
    logic ig, dg;
    step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, mrv, 32'h0, ig, dg);
  endtask

  initial begin
    logic       ig, dg;
    string      seq;
    string      exp_seq;
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; m_ready = 0; m_rvalid = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; m_rdata = 0;
    @(negedge clk);

    // Reset holds all control outputs low even with requests and responses present.
    step("rst", 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 32'h1, 4'hF, 1'b1, 1'b1, 32'h5, ig, dg);

    // Single fetch, response next cycle.
    step("fetch", 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, ig, dg);
    check_eq("fetch.gnt_const", ig, 1'b1);
    check_eq("fetch.addr_const", m_addr, 32'h10);
    step("fetch_rsp", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h93, ig, dg);
    #1 check_eq("fetch.busy_after", busy, 1'b0);

    // Contention: data wins until fetch has lost MAX_WAIT times.
    seq = "";
    for (int k = 0; k < 10; k++) begin
      step("cont", 1'b0, 1'b1, 32'h200 + 32'(k), 1'b1, 1'b0, 32'h300 + 32'(k), 32'h0, 4'hF,
           1'b1, (k > 0), 32'(k), ig, dg);
      seq = {seq, ig ? "I" : (dg ? "D" : "-")};
    end
    exp_seq = "DDDDIDDDDI";
    n_checks++;
    if (seq != exp_seq) begin
      n_errors++;
      $display("FAIL cont.seq: got %s expected %s", seq, exp_seq);
    end
    idle("cont_drain", 1'b1);

    // Back-pressure: FIFO fills, then a response frees a slot in the same cycle.
    step("full0", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, ig, dg);
    step("full1", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h404, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, ig, dg);
    step("full2", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h408, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, ig, dg);
    check_eq("full.blocked_gnt", dg, 1'b0);
    step("full3", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h408, 32'h0, 4'hF, 1'b1, 1'b1, 32'h7, ig, dg);
    check_eq("full.reenabled_gnt", dg, 1'b1);
    #1 check_eq("full.still_busy", busy, 1'b1);
    idle("full_drain0", 1'b1);
    idle("full_drain1", 1'b1);

    // Store with partial byte enables, then its acknowledge.
    step("store", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, 1'b1, 1'b0, 32'h0, ig, dg);
    check_eq("store.be_const", m_be, 32'h3);
    step("store_ack", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, ig, dg);

    // Memory stalls: nothing granted, then data wins on first ready.
    for (int k = 0; k < 3; k++)
      step("stall", 1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, ig, dg);
    step("stall_go", 1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, ig, dg);
    check_eq("stall.data_first", dg, 1'b1);
    idle("stall_drain", 1'b1);

    // Random traffic; memory only responds when something is outstanding.
    for (int k = 0; k < 400; k++) begin
      step("rand", ($urandom_range(0, 59) == 0),
           1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom),
           ($urandom_range(0, 3) != 0), (q.size() > 0) && 1'($urandom), $urandom, ig, dg);
    end
    step("rand_rst", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, ig, dg);

    // Stray response sets the sticky error; async reset clears it mid-cycle.
    idle("stray", 1'b1);
    step("outst", 1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, ig, dg);
    i_req = 1'b0;
    #1 check_eq("async.err_before", err, 1'b1);
    check_eq("async.busy_before", busy, 1'b1);
    rst = 1'b1;
    #1 check_eq("async.busy", busy, 1'b0);
    check_eq("async.err", err, 1'b0);
    q.delete(); starve = 0; m_err = 1'b0;
    @(negedge clk);
    step("post_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h9, ig, dg);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
